// File: rtl/pipeline_wb_regfile.sv
// Writeback stage and architectural register file: selects the writeback value,
// commits it on the clock edge and serves two write-first bypassed read ports.
module pipeline_wb_regfile #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            wb_regwrite,
  input  logic            wb_memtoreg,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_mem_data,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_fire,
  output logic            commit_pulse,
  output logic [4:0]      commit_rd,
  output logic [31:0]     write_count
);

  logic [XLEN-1:0] regs [NREG];

  always_comb begin
    wb_data = wb_memtoreg ? wb_mem_data : wb_alu_result;
  end

  // wb_valid gates first so unknown qualifiers on an empty slot resolve to 0.
  always_comb begin
    wb_fire = 1'b0;
    if (wb_valid && wb_regwrite && (wb_rd_addr != 5'd0)) begin
      wb_fire = 1'b1;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      if (wb_fire && (rs1_addr == wb_rd_addr)) begin
        rs1_data = wb_data;
      end else if (32'(rs1_addr) < NREG) begin
        rs1_data = regs[rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      if (wb_fire && (rs2_addr == wb_rd_addr)) begin
        rs2_data = wb_data;
      end else if (32'(rs2_addr) < NREG) begin
        rs2_data = regs[rs2_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      commit_pulse <= 1'b0;
      commit_rd    <= '0;
      write_count  <= '0;
    end else begin
      commit_pulse <= wb_fire;
      if (wb_fire) begin
        if (32'(wb_rd_addr) < NREG) begin
          regs[wb_rd_addr] <= wb_data;
        end
        commit_rd <= wb_rd_addr;
        if (write_count != '1) begin
          write_count <= write_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_wb_regfile.sv
// Randomized self-checking bench for pipeline_wb_regfile against an array-based
// architectural model of the register file and commit counters.
module tb_pipeline_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_regwrite, wb_memtoreg;
  logic [4:0]  wb_rd_addr, rs1_addr, rs2_addr;
  logic [63:0] wb_mem_data, wb_alu_result;
  logic [63:0] rs1_data, rs2_data, wb_data;
  logic        wb_fire, commit_pulse;
  logic [4:0]  commit_rd;
  logic [31:0] write_count;

  always #5 clk = ~clk;

  pipeline_wb_regfile #(.XLEN(64), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_rd_addr(wb_rd_addr), .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data),
    .wb_fire(wb_fire), .commit_pulse(commit_pulse), .commit_rd(commit_rd),
    .write_count(write_count)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [63:0] mregs [32];
  logic [31:0] mcount;
  logic        mpulse;
  logic [4:0]  mcrd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_fire();
    return (wb_valid === 1'b1) && (wb_regwrite === 1'b1) && (wb_rd_addr !== 5'd0);
  endfunction

  function automatic logic [63:0] exp_wbdata();
    return (wb_memtoreg === 1'b1) ? wb_mem_data : wb_alu_result;
  endfunction

  function automatic logic [63:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (exp_fire() && a == wb_rd_addr) return exp_wbdata();
    return mregs[a];
  endfunction

  // One clock: check combinational outputs, take the edge, update model, check registered outputs.
  task automatic step();
    logic        f;
    logic [63:0] d;
    #1;
    f = exp_fire();
    d = exp_wbdata();
    if (wb_valid === 1'b1) check("wb_data", wb_data, d);
    check("wb_fire", {63'd0, wb_fire}, {63'd0, f});
    check("rs1_data", rs1_data, exp_read(rs1_addr));
    check("rs2_data", rs2_data, exp_read(rs2_addr));
    @(posedge clk);
    if (reset) begin
      foreach (mregs[i]) mregs[i] = 64'd0;
      mcount = 32'd0;
      mpulse = 1'b0;
      mcrd   = 5'd0;
    end else begin
      mpulse = f;
      if (f) begin
        mregs[wb_rd_addr] = d;
        mcrd = wb_rd_addr;
        if (mcount != 32'hFFFF_FFFF) mcount = mcount + 32'd1;
      end
    end
    #1;
    check("commit_pulse", {63'd0, commit_pulse}, {63'd0, mpulse});
    check("commit_rd", {59'd0, commit_rd}, {59'd0, mcrd});
    check("write_count", {32'd0, write_count}, {32'd0, mcount});
  endtask

  task automatic drive_write(input logic [4:0] rd, input logic mem, input logic [63:0] val);
    wb_valid = 1'b1; wb_regwrite = 1'b1; wb_memtoreg = mem; wb_rd_addr = rd;
    wb_mem_data = mem ? val : {$urandom, $urandom};
    wb_alu_result = mem ? {$urandom, $urandom} : val;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_regwrite = 1'b0; wb_memtoreg = 1'b0; wb_rd_addr = 5'd0;
    wb_mem_data = 64'd0; wb_alu_result = 64'd0;
  endtask

  initial begin
    foreach (mregs[i]) mregs[i] = {$urandom, $urandom};
    mcount = 32'd0; mpulse = 1'b0; mcrd = 5'd0;
    idle();
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    reset = 1'b1;
    @(posedge clk); #1;
    step();
    reset = 1'b0;

    // Basic ALU write, then read it back.
    drive_write(5'd5, 1'b0, 64'h1234);
    step();
    idle();
    rs1_addr = 5'd5;
    #1;
    check("basic_rs1", rs1_data, 64'h1234);
    check("basic_pulse", {63'd0, commit_pulse}, 64'd1);
    check("basic_rd", {59'd0, commit_rd}, 64'd5);
    check("basic_count", {32'd0, write_count}, 64'd1);
    step();

    // Both ports hitting the bypass on a load writeback.
    drive_write(5'd7, 1'b1, 64'hDEAD_BEEF);
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    check("bypass_rs1", rs1_data, 64'hDEAD_BEEF);
    check("bypass_rs2", rs2_data, 64'hDEAD_BEEF);
    step();

    // Write to x0 is discarded.
    drive_write(5'd0, 1'b0, 64'hFFFF);
    rs1_addr = 5'd0;
    #1;
    check("x0_rs1", rs1_data, 64'd0);
    step();
    check("x0_pulse", {63'd0, commit_pulse}, 64'd0);
    check("x0_count", {32'd0, write_count}, 64'd2);

    // Invalid slot with unknown qualifiers and data.
    wb_valid = 1'b0; wb_regwrite = 1'bx; wb_memtoreg = 1'bx; wb_rd_addr = 5'bx;
    wb_mem_data = 'x; wb_alu_result = 'x;
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    for (int i = 0; i < 10; i++) step();
    check("xin_rs1", rs1_data, 64'h1234);
    check("xin_rs2", rs2_data, 64'hDEAD_BEEF);
    check("xin_count", {32'd0, write_count}, 64'd2);
    check("xin_pulse", {63'd0, commit_pulse}, 64'd0);

    // Reset wins over a coincident write.
    drive_write(5'd3, 1'b0, 64'h55);
    step();
    drive_write(5'd3, 1'b0, 64'hAA);
    rs1_addr = 5'd3;
    reset = 1'b1;
    #1;
    check("rst_bypass", rs1_data, 64'hAA);
    step();
    reset = 1'b0;
    idle();
    #1;
    check("rst_rs1", rs1_data, 64'd0);
    check("rst_count", {32'd0, write_count}, 64'd0);
    step();

    // Saturation: preset the counter, then three writes.
    force dut.write_count = 32'hFFFF_FFFD;
    #2;
    release dut.write_count;
    mcount = 32'hFFFF_FFFD;
    step();
    for (int i = 0; i < 3; i++) begin
      drive_write(5'($urandom_range(1, 31)), 1'($urandom), {$urandom, $urandom});
      step();
    end
    check("sat_count", {32'd0, write_count}, 64'hFFFF_FFFF);
    drive_write(5'd9, 1'b0, 64'h9);
    step();
    check("sat_hold", {32'd0, write_count}, 64'hFFFF_FFFF);
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Random traffic, biased toward bypass hits and x0.
    for (int n = 0; n < 400; n++) begin
      wb_valid      = ($urandom_range(0, 3) != 0);
      wb_regwrite   = ($urandom_range(0, 4) != 0);
      wb_memtoreg   = 1'($urandom);
      wb_rd_addr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_mem_data   = {$urandom, $urandom};
      wb_alu_result = {$urandom, $urandom};
      rs1_addr      = ($urandom_range(0, 2) == 0) ? wb_rd_addr : 5'($urandom);
      rs2_addr      = ($urandom_range(0, 2) == 0) ? wb_rd_addr : 5'($urandom);
      reset         = ($urandom_range(0, 59) == 0);
      step();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
